// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the byte-banked data memory.
// Size codes follow RV32 load/store funct3 encoding.
package data_mem_pkg;

    localparam int unsigned NB = 4;

    typedef enum logic [2:0] {
        SIZE_B  = 3'b000,
        SIZE_H  = 3'b001,
        SIZE_W  = 3'b010,
        SIZE_BU = 3'b100,
        SIZE_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT2 = 2'd1,
        RESP  = 2'd2
    } dm_state_e;

    // Byte count of an access; 0 marks an illegal size code.
    function automatic logic [2:0] size_bytes(input logic [2:0] size);
        case (size)
            SIZE_B, SIZE_BU: size_bytes = 3'd1;
            SIZE_H, SIZE_HU: size_bytes = 3'd2;
            SIZE_W:          size_bytes = 3'd4;
            default:         size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_bank.sv
// One byte lane of the data memory: DEPTH x 8 RAM with registered read.
// Read returns the old contents on a same-address write.
module data_mem_bank #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_banked.sv
// Byte-banked load/store data memory with valid/ready request and response.
// Word-crossing accesses run as two beats on word and word+1.
module data_mem_banked
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned XLEN        = 32,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [31:0]     req_addr,
    input  logic [2:0]      req_size,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    dm_state_e        state;
    logic             acc;
    logic [AW-1:0]    req_word;
    logic [1:0]       req_off;
    logic [2:0]       req_n;
    logic             req_legal;
    logic             req_cross;
    logic             req_err;
    logic [1:0]       rel [NB];
    logic [NB-1:0]    lane1;
    logic [NB-1:0]    lane2;
    logic [XLEN-1:0]  wrot;
    logic             addr_unused;

    logic [AW-1:0]    word_q;
    logic [AW-1:0]    word2_q;
    logic [NB-1:0]    lane2_q;
    logic [XLEN-1:0]  wrot_q;
    logic [1:0]       off_q;
    logic [2:0]       size_q;
    logic             write_q;
    logic             err_q;

    logic [NB-1:0]    bank_we;
    logic [AW-1:0]    bank_addr  [NB];
    logic [7:0]       bank_wdata [NB];
    logic [7:0]       bank_rdata [NB];

    logic [2:0]       n_q;
    logic [XLEN-1:0]  asm_data;
    logic [XLEN-1:0]  ext_data;

    assign addr_unused = ^req_addr[31:AW+2];

    assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign acc       = req_valid && req_ready;

    // Request decode: lane k carries access byte rel[k] = (k - off) mod 4.
    always_comb begin
        req_word  = req_addr[AW+1:2];
        req_off   = req_addr[1:0];
        req_n     = size_bytes(req_size);
        req_legal = (req_n != 3'd0) &&
                    !(req_write && ((req_size == SIZE_BU) || (req_size == SIZE_HU)));
        req_cross = ({1'b0, req_off} + req_n) > 3'd4;
        req_err   = !req_legal || (req_cross && !MISALIGN_EN);
        lane1     = '0;
        lane2     = '0;
        wrot      = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            rel[k] = 2'(k) - req_off;
            wrot[8*k +: 8] = req_wdata[{rel[k], 3'b000} +: 8];
            if ({1'b0, rel[k]} < req_n) begin
                if (2'(k) >= req_off) begin
                    lane1[k] = 1'b1;
                end else begin
                    lane2[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            word_q  <= '0;
            word2_q <= '0;
            lane2_q <= '0;
            wrot_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (acc) begin
            word_q  <= req_word;
            word2_q <= req_word + AW'(1);
            lane2_q <= req_err ? '0 : lane2;
            wrot_q  <= wrot;
            off_q   <= req_off;
            size_q  <= req_size;
            write_q <= req_write;
            err_q   <= req_err;
            state   <= (!req_err && req_cross) ? BEAT2 : RESP;
        end else begin
            case (state)
                BEAT2:   state <= RESP;
                RESP:    if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outside an accept each lane keeps addressing its own beat's word, so the
    // registered read data (and hence rsp_rdata) stays stable through RESP.
    always_comb begin
        for (int unsigned k = 0; k < NB; k++) begin
            bank_addr[k]  = acc ? req_word : (lane2_q[k] ? word2_q : word_q);
            bank_wdata[k] = acc ? wrot[8*k +: 8] : wrot_q[8*k +: 8];
            bank_we[k]    = acc ? (req_write && !req_err && lane1[k])
                                : ((state == BEAT2) && write_q && lane2_q[k]);
        end
    end

    for (genvar k = 0; k < NB; k++) begin : g_bank
        data_mem_bank #(
            .DEPTH (DEPTH)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[k]),
            .addr  (bank_addr[k]),
            .wdata (bank_wdata[k]),
            .rdata (bank_rdata[k])
        );
    end

    assign n_q = size_bytes(size_q);

    always_comb begin
        asm_data = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (3'(i) < n_q) begin
                asm_data[8*i +: 8] = bank_rdata[2'(2'(i) + off_q)];
            end
        end
        case (size_q)
            SIZE_B:  ext_data = {{24{asm_data[7]}}, asm_data[7:0]};
            SIZE_H:  ext_data = {{16{asm_data[15]}}, asm_data[15:0]};
            default: ext_data = asm_data;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign rsp_err   = (state == RESP) && err_q;
    assign rsp_rdata = ((state == RESP) && !write_q && !err_q) ? ext_data : '0;

endmodule

// File: tb/tb_data_mem_banked.sv
// Scoreboard bench for data_mem_banked: directed cases, hold/back-to-back,
// reset during a split store, random traffic, and a no-misalign build.
`timescale 1ns/1ps
module tb_data_mem_banked;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned MEMB  = 4 * DEPTH;
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_size = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [31:0] rsp_rdata;

    logic        n_req_valid = 1'b0, n_req_ready, n_req_write = 1'b0;
    logic [31:0] n_req_addr = '0, n_req_wdata = '0;
    logic [2:0]  n_req_size = '0;
    logic        n_rsp_valid, n_rsp_err;
    logic        n_rsp_ready = 1'b1;
    logic [31:0] n_rsp_rdata;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mdl [MEMB];
    int          n_checks = 0;
    int          n_fail = 0;
    int          acc_wait = 0;

    always #5 clk = ~clk;

    data_mem_banked #(.DEPTH(DEPTH), .XLEN(32), .MISALIGN_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_banked #(.DEPTH(DEPTH), .XLEN(32), .MISALIGN_EN(1'b0)) dut_na (
        .clk(clk), .rst_n(rst_n),
        .req_valid(n_req_valid), .req_ready(n_req_ready), .req_write(n_req_write),
        .req_addr(n_req_addr), .req_size(n_req_size), .req_wdata(n_req_wdata),
        .rsp_valid(n_rsp_valid), .rsp_ready(n_rsp_ready),
        .rsp_rdata(n_rsp_rdata), .rsp_err(n_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            SZ_B, SZ_BU: return 1;
            SZ_H, SZ_HU: return 2;
            SZ_W:        return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] addr, input logic [2:0] sz);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nbytes(sz); i++) begin
            v[8*i +: 8] = mdl[(addr + 32'(i)) % MEMB];
        end
        if (sz == SZ_B && v[7])  v[31:8]  = '1;
        if (sz == SZ_H && v[15]) v[31:16] = '1;
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the response has appeared.
    task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [2:0] sz, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input logic rdy_after);
        int lat;
        bit ok;
        exp_t e;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_size  = sz;
        req_wdata = wd;
        ok = 1'b0;
        acc_wait = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            acc_wait++;
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_accept"}, 32'(ok), 32'd1);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.tag = tag;
        e.rdata = exp_rd;
        e.err = exp_err;
        sb.push_back(e);
        if (wr && !exp_err) begin
            for (int i = 0; i < nbytes(sz); i++) mdl[(addr + 32'(i)) % MEMB] = wd[8*i +: 8];
        end
        #1;
        req_valid = 1'b0;
        rsp_ready = rdy_after;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        @(posedge clk);
        #1;
    endtask

    task automatic na_req(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [2:0] sz, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        n_req_valid = 1'b1;
        n_req_write = wr;
        n_req_addr  = addr;
        n_req_size  = sz;
        n_req_wdata = wd;
        @(negedge clk);
        check({tag, "_ready"}, 32'(n_req_ready), 32'd1);
        @(posedge clk);
        #1 n_req_valid = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, 32'(n_rsp_valid), 32'd1);
        check({tag, "_rdata"}, n_rsp_rdata, exp_rd);
        check({tag, "_err"}, 32'(n_rsp_err), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
                check({e.tag, "_err"}, 32'(rsp_err), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] szs [5];
        logic [31:0] a, wd, er;
        logic [2:0] sz;
        logic wr;
        int lat;
        szs = '{SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU};

        #3;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_req("sw_beef", 1, 32'h10, SZ_W, 32'hDEADBEEF, 32'h0, 0, 1, 1);
        do_req("lw_beef", 0, 32'h10, SZ_W, 32'h0, 32'hDEADBEEF, 0, 1, 1);
        do_req("sb_80",   1, 32'h13, SZ_B, 32'h80, 32'h0, 0, 1, 1);
        do_req("lb_80",   0, 32'h13, SZ_B, 32'h0, 32'hFFFFFF80, 0, 1, 1);
        do_req("lbu_80",  0, 32'h13, SZ_BU, 32'h0, 32'h00000080, 0, 1, 1);
        do_req("lw_mix",  0, 32'h10, SZ_W, 32'h0, 32'h80ADBEEF, 0, 1, 1);

        do_req("sw_1c",    1, 32'h1C, SZ_W, 32'hA0A1A2A3, 32'h0, 0, 1, 1);
        do_req("sw_20",    1, 32'h20, SZ_W, 32'hB0B1B2B3, 32'h0, 0, 1, 1);
        do_req("sw_cross", 1, 32'h1E, SZ_W, 32'h11223344, 32'h0, 0, 2, 1);
        do_req("lw_cross", 0, 32'h1E, SZ_W, 32'h0, 32'h11223344, 0, 2, 1);
        do_req("lw_1c",    0, 32'h1C, SZ_W, 32'h0, 32'h3344A2A3, 0, 1, 1);
        do_req("lw_20",    0, 32'h20, SZ_W, 32'h0, 32'hB0B11122, 0, 1, 1);

        do_req("sh_wrap",  1, MEMB - 1, SZ_H, 32'hA55A, 32'h0, 0, 2, 1);
        do_req("lhu_wrap", 0, MEMB - 1, SZ_HU, 32'h0, 32'h0000A55A, 0, 2, 1);
        do_req("lh_wrap",  0, MEMB - 1, SZ_H, 32'h0, 32'hFFFFA55A, 0, 2, 1);
        do_req("lb_0",     0, 32'h0, SZ_B, 32'h0, 32'hFFFFFFA5, 0, 1, 1);

        do_req("ill_ld",  0, 32'h10, 3'b011, 32'h0, 32'h0, 1, 1, 1);
        do_req("ill_st",  1, 32'h10, 3'b011, 32'hFFFFFFFF, 32'h0, 1, 1, 1);
        do_req("bu_st",   1, 32'h10, SZ_BU, 32'hFFFFFFFF, 32'h0, 1, 1, 1);
        do_req("ill_x",   0, 32'h1E, 3'b111, 32'h0, 32'h0, 1, 1, 1);
        do_req("lw_unch", 0, 32'h10, SZ_W, 32'h0, 32'h80ADBEEF, 0, 1, 1);

        rsp_ready = 1'b0;
        do_req("hold_ld", 0, 32'h10, SZ_W, 32'h0, 32'h80ADBEEF, 0, 1, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, 32'h80ADBEEF);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        do_req("b2b_st", 1, 32'h18, SZ_W, 32'h5555AAAA, 32'h0, 0, 1, 0);
        check("b2b_st_wait", 32'(acc_wait), 32'd1);
        rsp_ready = 1'b1;
        do_req("b2b_ld", 0, 32'h18, SZ_W, 32'h0, 32'h5555AAAA, 0, 1, 1);
        check("b2b_ld_wait", 32'(acc_wait), 32'd1);

        do_req("sw_40", 1, 32'h40, SZ_W, 32'h11111111, 32'h0, 0, 1, 1);
        do_req("sw_44", 1, 32'h44, SZ_W, 32'h22222222, 32'h0, 0, 1, 1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h42;
        req_size  = SZ_W;
        req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        check("rst_split_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        mdl[32'h42] = 8'h0D;
        mdl[32'h43] = 8'hF0;
        #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_split_valid", 32'(rsp_valid), 32'd0);
        check("rst_split_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_req("lw_40_after", 0, 32'h40, SZ_W, 32'h0, 32'hF00D1111, 0, 1, 1);
        do_req("lw_44_after", 0, 32'h44, SZ_W, 32'h0, 32'h22222222, 0, 1, 1);

        for (int w = 0; w < 16; w++) begin
            do_req("rnd_init", 1, 32'h100 + 32'(4 * w), SZ_W, $urandom, 32'h0, 0, 1, 1);
        end
        for (int r = 0; r < 40; r++) begin
            a  = 32'h100 + 32'($urandom_range(0, 60));
            wr = 1'($urandom_range(0, 1));
            sz = wr ? szs[$urandom_range(0, 2)] : szs[$urandom_range(0, 4)];
            wd = $urandom;
            lat = ((int'(a[1:0]) + nbytes(sz)) > 4) ? 2 : 1;
            er = wr ? 32'h0 : mdl_load(a, sz);
            do_req(wr ? "rnd_st" : "rnd_ld", wr, a, sz, wd, er, 0, lat, 1);
        end

        na_req("na_sw",    1, 32'h0, SZ_W, 32'h12345678, 32'h0, 0);
        na_req("na_lw_x",  0, 32'h2, SZ_W, 32'h0, 32'h0, 1);
        na_req("na_lh_x",  0, 32'h3, SZ_H, 32'h0, 32'h0, 1);
        na_req("na_sw_x",  1, 32'h2, SZ_W, 32'hFFFFFFFF, 32'h0, 1);
        na_req("na_lh",    0, 32'h2, SZ_H, 32'h0, 32'h00001234, 0);
        na_req("na_lw",    0, 32'h0, SZ_W, 32'h0, 32'h12345678, 0);

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
